// File: rtl/core_pkg.sv
// Shared decode definitions: ALU op codes, RV32I opcode/funct constants and the
// decode bundle handed from the decoder to the stage register.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADDI = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_ADD  = 4'd5
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    alu_op_e                 alu_op;
    logic [REG_ADDR_W-1:0]   rs1;
    logic [REG_ADDR_W-1:0]   rs2;
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN-1:0]         imm;
    logic                    reg_write;
    logic                    illegal;
  } decode_bundle_t;

  function automatic logic [XLEN-1:0] sext_i_imm(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = surrounding pipeline (fetch/execute), slave = the decode stage.
interface id_decode_stage_if
  import core_pkg::*;
();

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [3:0]            out_alu_op;
  logic [REG_ADDR_W-1:0] out_rs1;
  logic [REG_ADDR_W-1:0] out_rs2;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_imm;
  logic                  out_reg_write;
  logic                  out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_reg_write, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_reg_write, out_illegal
  );

endinterface

// File: rtl/id_decoder.sv
// Combinational RV32I decoder for ADDI and R-type ADD/SUB/AND/OR/XOR.
// Register indices are always extracted, even for illegal encodings.
module id_decoder
  import core_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    bundle           = '0;
    bundle.rs1       = instr[19:15];
    bundle.rs2       = instr[24:20];
    bundle.rd        = instr[11:7];
    bundle.alu_op    = ALU_ADDI;
    bundle.illegal   = 1'b1;
    bundle.reg_write = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          bundle.alu_op    = ALU_ADDI;
          bundle.imm       = sext_i_imm(instr);
          bundle.rs2       = '0;
          bundle.reg_write = 1'b1;
          bundle.illegal   = 1'b0;
        end
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          bundle.reg_write = 1'b1;
          bundle.illegal   = 1'b0;
          case (funct3)
            F3_ADD_SUB: bundle.alu_op = ALU_ADD;
            F3_AND:     bundle.alu_op = ALU_AND;
            F3_OR:      bundle.alu_op = ALU_OR;
            F3_XOR:     bundle.alu_op = ALU_XOR;
            default: begin
              bundle.reg_write = 1'b0;
              bundle.illegal   = 1'b1;
            end
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          bundle.alu_op    = ALU_SUB;
          bundle.reg_write = 1'b1;
          bundle.illegal   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage: single-entry pipeline register with valid/ready and flush.
// Define ID_DECODE_PERF_CNT_EN to add the perf_decoded / perf_illegal counters.
module id_decode_stage
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  id_decode_stage_if.slave   bus
`ifdef ID_DECODE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_decoded,
  output logic [31:0]        perf_illegal
`endif
);

  decode_bundle_t  dec;
  decode_bundle_t  bundle_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            load;

  id_decoder u_decoder (
    .instr  (bus.in_instr),
    .bundle (dec)
  );

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q  <= 1'b1;
      bundle_q <= dec;
      pc_q     <= bus.in_pc;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_alu_op    = bundle_q.alu_op;
  assign bus.out_rs1       = bundle_q.rs1;
  assign bus.out_rs2       = bundle_q.rs2;
  assign bus.out_rd        = bundle_q.rd;
  assign bus.out_imm       = bundle_q.imm;
  assign bus.out_reg_write = bundle_q.reg_write;
  assign bus.out_illegal   = bundle_q.illegal;

`ifdef ID_DECODE_PERF_CNT_EN
  // Counts only loads that survive the flush; both counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (load && !bus.flush) begin
      perf_decoded <= perf_decoded + 32'd1;
      if (dec.illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed scenarios then randomized traffic
// checked against a rule-level reference decoder.
module tb_id_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_decode_stage_if bus ();

`ifdef ID_DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded;
  logic [31:0] perf_illegal;
`endif

  id_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ID_DECODE_PERF_CNT_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        reg_write;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned mdl_decoded = 0;
  int unsigned mdl_illegal = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder written from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   op;
    int   opc;
    int   f3;
    int   f7;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    e.pc  = pc;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.imm = 32'd0;
    op    = -1;
    if (opc == 'h13 && f3 == 0) begin
      op    = 0;
      e.imm = 32'(int'($signed(w[31:20])));
      e.rs2 = 5'd0;
    end else if (opc == 'h33 && f7 == 0) begin
      if (f3 == 0) op = 5;
      if (f3 == 7) op = 2;
      if (f3 == 6) op = 3;
      if (f3 == 4) op = 4;
    end else if (opc == 'h33 && f7 == 'h20 && f3 == 0) begin
      op = 1;
    end
    e.illegal   = (op < 0);
    e.reg_write = (op >= 0);
    e.alu_op    = (op < 0) ? 4'd0 : 4'(op);
    return e;
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // One cycle of stimulus: drive after negedge, check in_ready, update the scoreboard at the edge.
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic exp_ready;
    logic accept;
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
    exp_ready = (sb.size() == 0) || rdy;
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
`ifdef ID_DECODE_PERF_CNT_EN
    check("perf_decoded", 64'(perf_decoded), 64'(mdl_decoded));
    check("perf_illegal", 64'(perf_illegal), 64'(mdl_illegal));
`endif
    accept = v && exp_ready && !fl;
    e = ref_decode(instr, pc);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else if (accept) begin
      sb.push_back(e);
      mdl_decoded++;
      if (e.illegal) mdl_illegal++;
    end
  endtask

  // Monitor: whenever the stage presents a bundle it must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        if (bus.out_valid && sb.size() != 0) begin
          e = sb[0];
          check("out_pc",        64'(bus.out_pc),        64'(e.pc));
          check("out_alu_op",    64'(bus.out_alu_op),    64'(e.alu_op));
          check("out_rs1",       64'(bus.out_rs1),       64'(e.rs1));
          check("out_rs2",       64'(bus.out_rs2),       64'(e.rs2));
          check("out_rd",        64'(bus.out_rd),        64'(e.rd));
          check("out_imm",       64'(bus.out_imm),       64'(e.imm));
          check("out_reg_write", 64'(bus.out_reg_write), 64'(e.reg_write));
          check("out_illegal",   64'(bus.out_illegal),   64'(e.illegal));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADDI_M1 = 32'hFFF0_8093;
  localparam logic [31:0] SUB_I   = 32'h4020_8133;
  localparam logic [31:0] ECALL   = 32'h0000_0073;

  initial begin
    logic [31:0] add_i, and_i, or_i, xor_i, w;
    add_i = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    and_i = r_type(7'h00, 5'd5, 5'd4, 3'b111, 5'd6);
    or_i  = r_type(7'h00, 5'd8, 5'd7, 3'b110, 5'd9);
    xor_i = r_type(7'h00, 5'd11, 5'd10, 3'b100, 5'd0);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid",     64'(bus.out_valid), 64'(0));
    check("rst_out_payload",   64'({bus.out_pc, bus.out_alu_op, bus.out_rs1, bus.out_rs2, bus.out_rd}), 64'(0));
    check("rst_out_imm",       64'(bus.out_imm), 64'(0));
    check("rst_out_flags",     64'({bus.out_reg_write, bus.out_illegal}), 64'(0));
`ifdef ID_DECODE_PERF_CNT_EN
    check("rst_perf",          64'({perf_decoded, perf_illegal}), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI with negative immediate, then SUB.
    drive(1'b1, ADDI_M1, 32'h100, 1'b1, 1'b0);
    drive(1'b1, SUB_I,   32'h104, 1'b1, 1'b0);
    // Back-to-back R-type stream.
    drive(1'b1, add_i, 32'h108, 1'b1, 1'b0);
    drive(1'b1, and_i, 32'h10C, 1'b1, 1'b0);
    drive(1'b1, or_i,  32'h110, 1'b1, 1'b0);
    drive(1'b1, xor_i, 32'h114, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0,   1'b1, 1'b0);

    // Backpressure: held ADD must stay stable while a new instruction waits.
    drive(1'b1, add_i, 32'h200, 1'b0, 1'b0);
    repeat (3) drive(1'b1, xor_i, 32'h204, 1'b0, 1'b0);
    drive(1'b1, xor_i, 32'h204, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0,   1'b1, 1'b0);

    // Illegal encoding is passed along, not dropped.
    drive(1'b1, ECALL, 32'h300, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0,   1'b1, 1'b0);

    // Flush kills the held bundle and the concurrent input.
    drive(1'b1, add_i,  32'h400, 1'b0, 1'b0);
    drive(1'b1, SUB_I,  32'h404, 1'b0, 1'b1);
    drive(1'b0, 32'h0,  32'h0,   1'b1, 1'b0);

    // Asynchronous reset while a bundle is held.
    drive(1'b1, or_i, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    sb.delete();
    mdl_decoded = 0;
    mdl_illegal = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
        1:       w = r_type(7'h00, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom));
        2:       w = r_type(7'h20, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom));
        3:       w = r_type(7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
        4:       w = r_type(7'h20, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
        5:       w = {17'($urandom), 3'($urandom), 5'($urandom), 7'b0010011};
        default: w = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, w, {$urandom_range(0, 65535), 2'b00},
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered instruction-decode stage that generates the operation code, operand indices and immediate consumed by the execute-stage ALU.
- Accepts a fetched 32-bit RV32I instruction via valid/ready and decodes ADDI plus R-type ADD/SUB/AND/OR/XOR.
- Holds the result in a single-entry pipeline register with valid/ready toward execute.
- Flags unsupported encodings as illegal instead of dropping them.

Parameters:
- XLEN, 32, datapath/immediate width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept instruction this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  kill held and incoming instruction (branch/exception redirect)
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered PC
- out_alu_op  out  4  ALU operation code (see package)
- out_rs1  out  REG_ADDR_W  source register 1 index
- out_rs2  out  REG_ADDR_W  source register 2 index
- out_rd  out  REG_ADDR_W  destination index
- out_imm  out  XLEN  sign-extended I-immediate; 0 for R-type
- out_reg_write  out  1  writeback enable
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset:
  - out_valid=0.
  - All other outputs reset to 0: out_pc, out_alu_op, out_rs1, out_rs2, out_rd, out_imm, out_reg_write, out_illegal.
  - Counters (if enabled) reset to 0.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
  - Load when in_valid && in_ready.
  - Payload and out_valid update on the same clk edge, giving 1-cycle latency.
  - If out_ready=1 and no load occurs, out_valid clears.
  - out_valid=1 && out_ready=0 holds all outputs stable.
- Flush:
  - Has priority: on the next edge out_valid=0 and any concurrent input is discarded.
  - in_ready is not gated by flush.
- Decode, with ALU op codes as listed in the package:
  - opcode 0010011, funct3 000: ADDI. alu_op=0, imm=sext(instr[31:20]), rs2=0, reg_write=1.
  - opcode 0110011, funct7 0000000: funct3 000 ADD→5, 111 AND→2, 110 OR→3, 100 XOR→4. imm=0, reg_write=1.
  - opcode 0110011, funct7 0100000, funct3 000: SUB→1. imm=0, reg_write=1.
  - Field positions: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
  - Anything else: illegal=1, alu_op=0, reg_write=0, imm=0. rs1, rs2 and rd are still captured.
- rd=0 on a legal instruction keeps reg_write=1; the register file discards writes to x0.
- Decode is a combinational function of in_instr feeding the register; no state machine beyond the valid bit.
- Reset asserted mid-transfer: out_valid drops immediately (asynchronously); the in-flight instruction is lost.

Optional Feature:
- Macro ID_DECODE_PERF_CNT_EN.
- Enabled:
  - Adds outputs perf_decoded (32) and perf_illegal (32).
  - perf_decoded increments on each accepted, non-flushed load.
  - perf_illegal increments when that load is illegal.
  - Both wrap at 2^32.
- Disabled: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - ALU_ADDI=4'd0, ALU_SUB=4'd1, ALU_AND=4'd2, ALU_OR=4'd3, ALU_XOR=4'd4, ALU_ADD=4'd5.
  - OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011.
  - The funct3/funct7 constants.
  - A packed typedef decode_bundle_t covering alu_op, rs1, rs2, rd, imm, reg_write, illegal.
- One natural combinational sub-module, id_decoder: instruction → decode_bundle_t.
- The stage module owns handshake, register and counters.

Test Plan:
- Reset then in_valid=1, instr=0xFFF08093 (addi x1,x1,-1), out_ready=1 → next cycle: out_valid=1, alu_op=0, rs1=1, rd=1, imm=0xFFFFFFFF, reg_write=1, illegal=0.
- instr=0x40208133 (sub x2,x1,x2) → alu_op=1, rs1=1, rs2=2, rd=2, imm=0.
- Stream add/and/or/xor back-to-back with out_ready=1 → one result per cycle, alu_op 5, 2, 3, 4 in order, in_ready held 1.
- Backpressure: load add, then hold out_ready=0 for 3 cycles with a new in_valid → in_ready=0 and outputs stable. Release → the add is consumed, then the next instruction appears one cycle later.
- instr=0x00000073 (ecall) → out_valid=1, illegal=1, reg_write=0, alu_op=0. perf_illegal=1 if the macro is enabled.
- flush asserted with out_valid=1 and in_valid=1 → out_valid=0 next cycle; perf_decoded unchanged.
